regfile_wb_sink: RTL and testbench

Architectural register file that terminates the writeback side of the 5-stage MIPS32 pipeline. It accepts one register write per cycle from the writeback stage and serves two registered read ports to the decode stage. A 32-entry pending-write scoreboard raises a stall when decode reads a register whose producer has not yet written back. A latched halt freezes all architectural state once the writeback stage signals halt.

---
 rtl/regfile_wb_sink_if.sv | 27 ++
 rtl/regfile_wb_sink.sv | 83 ++++++++
 tb/tb_regfile_wb_sink.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sink_if.sv
// Writeback/decode bus of the MIPS32 register file sink.
// master = pipeline side (drives writes, reads, issue); slave = register file.
interface regfile_wb_sink_if;
  logic        wren;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        halt_f;
  logic [4:0]  rd1;
  logic [4:0]  rd2;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        stall;
  logic        halted;
  logic [15:0] wr_count;

  modport master (
    output wren, wraddr, wrdata, halt_f, rd1, rd2, pend_set, pend_addr,
    input  rdata1, rdata2, stall, halted, wr_count
  );

  modport slave (
    input  wren, wraddr, wrdata, halt_f, rd1, rd2, pend_set, pend_addr,
    output rdata1, rdata2, stall, halted, wr_count
  );
endinterface

// File: rtl/regfile_wb_sink.sv
// MIPS32 architectural register file with pending-write scoreboard and sticky halt.
// Optional macro REGFILE_BYPASS_EN: write-first reads and commit-aware stall.
module regfile_wb_sink (
  input  logic             clk,
  input  logic             rst,
  regfile_wb_sink_if.slave bus
);
  localparam int DEPTH = 32;
  localparam int WIDTH = 32;

  logic [WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0] pending_reg, pending_next;
  logic [DEPTH-1:0] commit_onehot, set_onehot, pend_view;
  logic             halted_reg;
  logic [15:0]      wr_count_reg;
  logic [WIDTH-1:0] rdata1_reg, rdata2_reg;
  logic [WIDTH-1:0] rd1_val, rd2_val;
  logic             commit;
  logic             stall_c;

  assign commit = bus.wren && !halted_reg && !bus.halt_f && (bus.wraddr != 5'd0);

  // Per-register decode of this cycle's commit (clear) and issue (set); r0 never pends.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign commit_onehot[gi] = commit && (bus.wraddr == 5'(gi));
      if (gi == 0) begin : g_zero
        assign set_onehot[gi] = 1'b0;
      end else begin : g_nz
        assign set_onehot[gi] = bus.pend_set && !halted_reg && (bus.pend_addr == 5'(gi));
      end
    end
  endgenerate

  // Set is OR-ed in after the clear so a same-cycle set wins.
  assign pending_next = (pending_reg & ~commit_onehot) | set_onehot;

  always_comb begin
    rd1_val   = regs_reg[bus.rd1];
    rd2_val   = regs_reg[bus.rd2];
    pend_view = pending_reg;
`ifdef REGFILE_BYPASS_EN
    if (commit && (bus.wraddr == bus.rd1)) rd1_val = bus.wrdata;
    if (commit && (bus.wraddr == bus.rd2)) rd2_val = bus.wrdata;
    pend_view = pending_reg & ~commit_onehot;
`endif
    if (bus.rd1 == 5'd0) rd1_val = '0;
    if (bus.rd2 == 5'd0) rd2_val = '0;
    stall_c = ((bus.rd1 != 5'd0) && pend_view[bus.rd1]) ||
              ((bus.rd2 != 5'd0) && pend_view[bus.rd2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
    end else if (commit) begin
      regs_reg[bus.wraddr] <= bus.wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg  <= '0;
      halted_reg   <= 1'b0;
      wr_count_reg <= '0;
      rdata1_reg   <= '0;
      rdata2_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      halted_reg  <= halted_reg | bus.halt_f;
      if (commit) wr_count_reg <= wr_count_reg + 16'd1;
      rdata1_reg  <= rd1_val;
      rdata2_reg  <= rd2_val;
    end
  end

  assign bus.rdata1   = rdata1_reg;
  assign bus.rdata2   = rdata2_reg;
  assign bus.stall    = stall_c;
  assign bus.halted   = halted_reg;
  assign bus.wr_count = wr_count_reg;
endmodule

// File: tb/tb_regfile_wb_sink.sv
// Testbench for regfile_wb_sink: directed vector table, then random traffic vs a model.
module tb_regfile_wb_sink;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_sink_if bus ();

  regfile_wb_sink dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        rst;
    bit        wren;
    bit [4:0]  wraddr;
    bit [31:0] wrdata;
    bit        halt_f;
    bit [4:0]  rd1;
    bit [4:0]  rd2;
    bit        pend_set;
    bit [4:0]  pend_addr;
    bit        chk_st;
    bit        e_st;
    bit [31:0] e_r1;
    bit [31:0] e_r2;
    bit [15:0] e_cnt;
    bit        e_halt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int step  = 0;

  // Reference state: architectural view only.
  bit [31:0] m_regs [32];
  bit        m_pend [32];
  bit        m_halt = 1'b0;
  bit [15:0] m_cnt  = '0;

  function automatic vec_t mk(bit r, bit we, bit [4:0] wa, bit [31:0] wd, bit hf,
                              bit [4:0] a1, bit [4:0] a2, bit ps, bit [4:0] pa,
                              bit cs, bit es, bit [31:0] e1, bit [31:0] e2,
                              bit [15:0] ec, bit eh);
    vec_t v;
    v.rst = r; v.wren = we; v.wraddr = wa; v.wrdata = wd; v.halt_f = hf;
    v.rd1 = a1; v.rd2 = a2; v.pend_set = ps; v.pend_addr = pa;
    v.chk_st = cs; v.e_st = es; v.e_r1 = e1; v.e_r2 = e2; v.e_cnt = ec; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst           = v.rst;
    bus.wren      = v.wren;
    bus.wraddr    = v.wraddr;
    bus.wrdata    = v.wrdata;
    bus.halt_f    = v.halt_f;
    bus.rd1       = v.rd1;
    bus.rd2       = v.rd2;
    bus.pend_set  = v.pend_set;
    bus.pend_addr = v.pend_addr;
    #1;
    if (v.chk_st) chk("stall", 32'(bus.stall), 32'(v.e_st));
    @(posedge clk);
    #1;
    chk("rdata1", bus.rdata1, v.e_r1);
    chk("rdata2", bus.rdata2, v.e_r2);
    chk("wr_count", 32'(bus.wr_count), 32'(v.e_cnt));
    chk("halted", 32'(bus.halted), 32'(v.e_halt));
    $display("txn %0d rst=%b we=%b wa=%0d wd=%h hf=%b rd=%0d/%0d ps=%b pa=%0d -> r1=%h r2=%h st=%b cnt=%0d h=%b",
             step, v.rst, v.wren, v.wraddr, v.wrdata, v.halt_f, v.rd1, v.rd2, v.pend_set,
             v.pend_addr, bus.rdata1, bus.rdata2, v.e_st, bus.wr_count, bus.halted);
    step++;
  endtask

  // Expected outputs from the architectural rules, then advance the model one edge.
  task automatic model_step(inout vec_t v);
    bit cm, p1, p2;
    cm = v.wren && !m_halt && !v.halt_f && (v.wraddr != 0);
    p1 = m_pend[v.rd1];
    p2 = m_pend[v.rd2];
    if (BYP && cm && v.wraddr == v.rd1) p1 = 1'b0;
    if (BYP && cm && v.wraddr == v.rd2) p2 = 1'b0;
    v.chk_st = 1'b1;
    v.e_st   = (v.rd1 != 0 && p1) || (v.rd2 != 0 && p2);
    if (v.rst) begin
      v.e_r1 = 0; v.e_r2 = 0;
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_halt = 0; m_cnt = 0;
    end else begin
      v.e_r1 = (v.rd1 == 0) ? 32'd0 : (BYP && cm && v.wraddr == v.rd1) ? v.wrdata : m_regs[v.rd1];
      v.e_r2 = (v.rd2 == 0) ? 32'd0 : (BYP && cm && v.wraddr == v.rd2) ? v.wrdata : m_regs[v.rd2];
      if (cm) begin
        m_regs[v.wraddr] = v.wrdata;
        m_pend[v.wraddr] = 1'b0;
        m_cnt = m_cnt + 1;
      end
      if (v.pend_set && v.pend_addr != 0 && !m_halt) m_pend[v.pend_addr] = 1'b1;
      m_halt = m_halt | v.halt_f;
    end
    v.e_cnt  = m_cnt;
    v.e_halt = m_halt;
  endtask

  vec_t vq[$];
  vec_t rv;

  initial begin
    // Reset held two cycles, then sweep every register on both ports.
    vq.push_back(mk(1,0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0));
    vq.push_back(mk(1,0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0));
    for (int i = 1; i < 32; i++)
      vq.push_back(mk(0,0,0,0,0, 5'(i),5'(32-i), 0,0, 1,0, 0,0, 0,0));
    // Basic write/read and r0 protection.
    vq.push_back(mk(0,1,5,32'hDEADBEEF,0, 0,0, 0,0, 1,0, 0,0, 1,0));
    vq.push_back(mk(0,0,0,0,0, 5,0, 0,0, 1,0, 32'hDEADBEEF,0, 1,0));
    vq.push_back(mk(0,1,0,32'hFFFFFFFF,0, 0,0, 0,0, 1,0, 0,0, 1,0));
    vq.push_back(mk(0,0,0,0,0, 5,0, 0,0, 1,0, 32'hDEADBEEF,0, 1,0));
    // Collision on r7.
    vq.push_back(mk(0,1,7,32'hA,0, 0,0, 0,0, 1,0, 0,0, 2,0));
    vq.push_back(mk(0,1,7,32'h12345678,0, 7,0, 0,0, 1,0, BYP ? 32'h12345678 : 32'hA,0, 3,0));
    vq.push_back(mk(0,0,0,0,0, 7,0, 0,0, 1,0, 32'h12345678,0, 3,0));
    // Scoreboard on r9, with an unrelated write to r10 while r9 pends.
    vq.push_back(mk(0,0,0,0,0, 0,9, 1,9, 1,0, 0,0, 3,0));
    vq.push_back(mk(0,0,0,0,0, 0,9, 0,0, 1,1, 0,0, 3,0));
    vq.push_back(mk(0,1,10,32'h10,0, 0,9, 0,0, 1,1, 0,0, 4,0));
    vq.push_back(mk(0,0,0,0,0, 10,9, 0,0, 1,1, 32'h10,0, 4,0));
    vq.push_back(mk(0,1,9,32'h99,0, 0,9, 0,0, 1,!BYP, 0,BYP ? 32'h99 : 32'h0, 5,0));
    vq.push_back(mk(0,0,0,0,0, 0,9, 0,0, 1,0, 0,32'h99, 5,0));
    vq.push_back(mk(0,1,9,32'h100,0, 0,9, 1,9, 1,0, 0,BYP ? 32'h100 : 32'h99, 6,0));
    vq.push_back(mk(0,0,0,0,0, 0,9, 0,0, 1,1, 0,32'h100, 6,0));
    vq.push_back(mk(0,1,9,32'h101,0, 0,9, 0,0, 1,!BYP, 0,BYP ? 32'h101 : 32'h100, 7,0));
    vq.push_back(mk(0,0,0,0,0, 9,0, 0,0, 1,0, 32'h101,0, 7,0));
    // Halt: same-cycle write dropped, later write and issue ignored, reads continue.
    vq.push_back(mk(0,1,3,32'h55,1, 3,0, 0,0, 1,0, 0,0, 7,1));
    vq.push_back(mk(0,1,4,32'h44,0, 4,12, 1,12, 1,0, 0,0, 7,1));
    vq.push_back(mk(0,0,0,0,0, 3,12, 0,0, 1,0, 0,0, 7,1));
    vq.push_back(mk(0,0,0,0,0, 4,5, 0,0, 1,0, 0,32'hDEADBEEF, 7,1));
    vq.push_back(mk(1,0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0));
    vq.push_back(mk(0,0,0,0,0, 5,0, 0,0, 1,0, 0,0, 0,0));

    foreach (vq[i]) apply(vq[i]);

    // Random traffic on a narrow address window so collisions and stalls are frequent.
    for (int t = 0; t < 2000; t++) begin
      rv.rst       = (t == 0) || ($urandom_range(0, 149) == 0);
      rv.wren      = ($urandom_range(0, 3) != 0);
      rv.wraddr    = 5'($urandom_range(0, 7));
      rv.wrdata    = $urandom;
      rv.halt_f    = ($urandom_range(0, 399) == 0);
      rv.rd1       = 5'($urandom_range(0, 7));
      rv.rd2       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      rv.pend_set  = ($urandom_range(0, 2) == 0);
      rv.pend_addr = 5'($urandom_range(0, 7));
      model_step(rv);
      apply(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
